hazard_unit_scoreboard: RTL
===========================

Name: hazard_unit_scoreboard

Overview:
- Parametrised successor to the single-cycle load-use stall detector.
- Sits beside the ID stage and owns all pipeline hold and kill controls.
- Keeps a per-register countdown scoreboard, so loads with a configurable latency stall dependants for exactly the required number of cycles.
- Also freezes the whole pipeline on data-memory wait states, applies branch flushes with a fixed priority, and counts stall cycles for performance monitoring.

Parameters:
- NUM_REGS, 32: architectural register count; x0 is never tracked.
- REG_AW, 5: register address width; must be at least clog2(NUM_REGS).
- LOAD_LAT, 1: number of issue slots a dependant must wait after a load before the loaded value is forwardable. 1 gives the classic single bubble; legal range is 1..7.
- CNT_W, 3: width of each scoreboard counter; must be at least clog2(LOAD_LAT+1).
- STALL_CNT_W, 32: width of the performance stall counter.

Ports:
- clk in 1: the only clock.
- rst_n in 1: synchronous, active-low reset.
- id_valid in 1: a valid instruction occupies ID.
- id_opcode in 7: opcode of the instruction in ID.
- id_rs1 in REG_AW: source register 1 of the instruction in ID.
- id_rs2 in REG_AW: source register 2 of the instruction in ID.
- id_rd in REG_AW: destination register of the instruction in ID.
- mem_busy in 1: data memory has not completed its access this cycle.
- ex_branch_taken in 1: EX has resolved a taken branch or jump; redirect this cycle.
- stall_pc out 1: hold the PC.
- stall_ifid out 1: hold the IF/ID register.
- bubble_idex out 1: load a NOP into ID/EX.
- flush_ifid out 1: clear the IF/ID register.
- freeze out 1: hold every stage register, including EX/MEM and MEM/WB.
- stall_count out STALL_CNT_W: saturating count of stalled cycles.
- pending_mask out NUM_REGS: bit r is 1 while cnt[r] is nonzero. Bit 0 is always 0.

Behaviour:
- All clock activity is on the rising edge of clk. rst_n is synchronous and active-low.
- While rst_n is low:
  - all cnt[r] clear to 0 and stall_count clears to 0;
  - all control outputs are forced to 0;
  - pending_mask reads 0.
- Source-use decode:
  - R-type (0110011), STORE (0100011) and BRANCH (1100011) use rs1 and rs2.
  - I-ALU (0010011), LOAD (0000011) and JALR (1100111) use rs1 only.
  - Every other opcode uses no sources.
- Destination write:
  - R-type, I-ALU, LOAD, JAL, JALR, LUI and AUIPC write rd.
  - A write only counts when rd is nonzero.
- Definitions used below:
  - hazard = id_valid AND (uses rs1 AND cnt[rs1] != 0, OR uses rs2 AND cnt[rs2] != 0).
  - issue = id_valid AND NOT freeze AND NOT ex_branch_taken AND NOT hazard.
- Output priority (combinational from current state and inputs; zero latency):
  1. mem_busy: freeze=1, stall_pc=1, stall_ifid=1. bubble_idex=0 and flush_ifid=0. A pending ex_branch_taken must be held by EX and re-presented later.
  2. else ex_branch_taken: flush_ifid=1 and bubble_idex=1. The ID instruction is killed, even if it is hazarded.
  3. else hazard: stall_pc=1, stall_ifid=1, bubble_idex=1.
  4. else all outputs are 0.
- Scoreboard update on each edge, with rst_n high:
  - If freeze is high, every counter holds.
  - Otherwise every nonzero counter decrements by 1.
  - Then, if issue is high and the instruction writes rd, cnt[rd] is overwritten:
    - LOAD sets cnt[rd] = LOAD_LAT;
    - any other rd-writer sets cnt[rd] = 0.
    - The overwrite takes precedence over that counter's decrement in the same cycle.
  - A younger non-load write to rd therefore cancels an older pending load on rd, because forwarding supplies the youngest value.
- stall_count increments when rst_n is high and (freeze OR (hazard AND NOT ex_branch_taken)). It saturates at all ones.
- Boundary conditions:
  - rs equal to 0, or an opcode that does not use that source, never stalls.
  - A load with rd=0 is never tracked.
  - Back-to-back loads to different rd are tracked independently.
  - A reset asserted during a stall takes effect at the next edge. The cycle after reset deasserts has no stall.

Decomposition:
- Shared package hazard_pkg holds:
  - the opcode localparams OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC;
  - the rule that pipeline registers treat freeze with higher priority than bubble.
- One natural sub-module, rv_operand_use_decode: combinational; takes the opcode and produces use_rs1, use_rs2 and writes_rd.
- The top level contains the counter array, the hazard compare and the performance counter.

Test Plan:
- Load then dependent use, LOAD_LAT=1: cycle 0 LOAD x5; cycle 1 ADD x6,x5,x1 -> cycle 1 shows stall_pc=stall_ifid=bubble_idex=1; cycle 2 clear; stall_count=1.
- LOAD_LAT=3, LOAD x7 then an immediate user of x7 -> exactly 3 stall cycles, then issue; pending_mask[7] goes 1 for 3 cycles then 0.
- LOAD x0 followed by ADD x1,x0,x0; and LUI x5 followed by LOAD x5 with no x5 dependency -> no stall in either case.
- Hazarded instruction in ID while ex_branch_taken=1 -> flush_ifid=1, bubble_idex=1, stall_pc=0; stall_count unchanged.
- mem_busy high for 4 cycles with cnt[9]=1 -> freeze=1 for 4 cycles and cnt[9] holds at 1; stall_count advances by 4; the dependant then stalls 1 more cycle.
- LOAD x3 then ADDI x3 issued, then a user of x3 -> no stall after the ADDI. Separately, rst_n low mid-stall -> outputs 0 and pending_mask=0 on the next edge.

Source files
------------

// File: rtl/hazard_unit_scoreboard_pkg.sv
// Shared definitions for the hazard unit slice.
//   - opcode_e : RV32I major opcodes seen by the ID-stage hazard logic
//   - pipe_reg_action() : how a stage register combines freeze and bubble
package hazard_pkg;

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_I      = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [1:0] {
        REG_LOAD,
        REG_BUBBLE,
        REG_HOLD
    } pipe_reg_act_e;

    // A frozen stage register must keep its contents even when a bubble is
    // also requested; otherwise a NOP would overwrite an instruction that is
    // still waiting on data memory.
    function automatic pipe_reg_act_e pipe_reg_action(input logic freeze,
                                                      input logic bubble);
        if (freeze)      return REG_HOLD;
        else if (bubble) return REG_BUBBLE;
        else             return REG_LOAD;
    endfunction

endpackage

// File: rtl/hazard_unit_scoreboard_if.sv
// ID-stage / hazard-unit signal bundle.
//   master : pipeline side, drives the ID instruction fields, mem_busy and
//            ex_branch_taken; receives hold/kill controls and monitors.
//   slave  : hazard unit side.
interface hazard_unit_scoreboard_if #(
    parameter int NUM_REGS    = 32,
    parameter int REG_AW      = 5,
    parameter int STALL_CNT_W = 32
) ();
    logic                   id_valid;
    logic [6:0]             id_opcode;
    logic [REG_AW-1:0]      id_rs1;
    logic [REG_AW-1:0]      id_rs2;
    logic [REG_AW-1:0]      id_rd;
    logic                   mem_busy;
    logic                   ex_branch_taken;
    logic                   stall_pc;
    logic                   stall_ifid;
    logic                   bubble_idex;
    logic                   flush_ifid;
    logic                   freeze;
    logic [STALL_CNT_W-1:0] stall_count;
    logic [NUM_REGS-1:0]    pending_mask;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, mem_busy, ex_branch_taken,
        input  stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze, stall_count,
               pending_mask
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, mem_busy, ex_branch_taken,
        output stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze, stall_count,
               pending_mask
    );
endinterface

// File: rtl/hazard_unit_scoreboard_decode.sv
// rv_operand_use_decode: combinational opcode decode of register usage.
//   opcode    in  7 : major opcode of the ID instruction
//   use_rs1   out 1 : instruction reads rs1
//   use_rs2   out 1 : instruction reads rs2
//   writes_rd out 1 : instruction writes rd (rd==0 filtering is done by caller)
module rv_operand_use_decode
    import hazard_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       use_rs1,
    output logic       use_rs2,
    output logic       writes_rd
);
    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OP_R: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writes_rd = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_I, OP_LOAD, OP_JALR: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
            end
            OP_JAL, OP_LUI, OP_AUIPC: begin
                writes_rd = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/hazard_unit_scoreboard.sv
// hazard_unit_scoreboard: ID-stage owner of all pipeline hold/kill controls.
// A per-register countdown scoreboard stalls dependants of loads for exactly
// LOAD_LAT issue slots; mem_busy freezes everything; a taken branch kills ID.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of hazard_unit_scoreboard_if
//                in : id_valid, id_opcode, id_rs1, id_rs2, id_rd, mem_busy,
//                     ex_branch_taken
//                out: stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze,
//                     stall_count (saturating), pending_mask (cnt[r] != 0)
module hazard_unit_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int REG_AW      = 5,
    parameter int LOAD_LAT    = 1,
    parameter int CNT_W       = 3,
    parameter int STALL_CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    hazard_unit_scoreboard_if.slave   bus
);
    logic                   use_rs1;
    logic                   use_rs2;
    logic                   writes_rd;
    logic                   is_load;
    logic                   hazard;
    logic                   freeze_i;
    logic                   issue;
    logic                   stall_cnt_en;
    logic [NUM_REGS-1:0]    pend;
    logic [CNT_W-1:0]       cnt [NUM_REGS];
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    rv_operand_use_decode u_decode (
        .opcode    (bus.id_opcode),
        .use_rs1   (use_rs1),
        .use_rs2   (use_rs2),
        .writes_rd (writes_rd)
    );

    // x0 is never tracked, so pend[0] stays 0 and rs==0 can never stall.
    always_comb begin
        pend = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            pend[r] = (cnt[r] != '0);
        end
    end

    always_comb begin
        is_load      = (bus.id_opcode == OP_LOAD);
        hazard       = bus.id_valid && ((use_rs1 && pend[bus.id_rs1]) ||
                                        (use_rs2 && pend[bus.id_rs2]));
        freeze_i     = rst_n && bus.mem_busy;
        issue        = bus.id_valid && !freeze_i && !bus.ex_branch_taken && !hazard;
        stall_cnt_en = freeze_i || (hazard && !bus.ex_branch_taken);
    end

    // Priority: mem_busy > ex_branch_taken > hazard; everything gated by reset.
    always_comb begin
        bus.freeze       = freeze_i;
        bus.stall_pc     = rst_n && (bus.mem_busy || (!bus.ex_branch_taken && hazard));
        bus.stall_ifid   = rst_n && (bus.mem_busy || (!bus.ex_branch_taken && hazard));
        bus.bubble_idex  = rst_n && !bus.mem_busy && (bus.ex_branch_taken || hazard);
        bus.flush_ifid   = rst_n && !bus.mem_busy && bus.ex_branch_taken;
        bus.pending_mask = rst_n ? pend : '0;
        bus.stall_count  = rst_n ? stall_cnt_q : '0;
    end

    // The rd overwrite is placed after the decrement loop so that it wins for
    // that counter; a younger non-load writer clears an older pending load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else if (!freeze_i) begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
            end
            if (issue && writes_rd && (bus.id_rd != '0)) begin
                cnt[bus.id_rd] <= is_load ? CNT_W'(LOAD_LAT) : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_cnt_en && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end
endmodule
